// File: rtl/l2_port_arbiter_pkg.sv
// Shared types and constants for the I/D miss-port arbiter in front of the unified L2.
package l2_port_arbiter_pkg;
   localparam int L2A_ADDR_W = 32;
   localparam int L2A_LINE_W = 256;

   typedef enum logic [1:0] {IDLE, GNT_I, GNT_D, RELEASE} arb_state_t;
   typedef enum logic {PORT_I, PORT_D} port_t;
endpackage

// File: rtl/l2_port_arbiter.sv
// Round-robin arbiter sharing the L2 line port between the I-cache and D-cache miss ports.
// One transaction in flight; L2 address/data/op are held in registers for the whole grant.
module l2_port_arbiter
   import l2_port_arbiter_pkg::*;
#(
   parameter int ADDR_W = L2A_ADDR_W,
   parameter int LINE_W = L2A_LINE_W
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              i_read,
   input  logic [ADDR_W-1:0] i_addr,
   output logic [LINE_W-1:0] i_rdata,
   output logic              i_resp,
   input  logic              d_read,
   input  logic              d_write,
   input  logic [ADDR_W-1:0] d_addr,
   input  logic [LINE_W-1:0] d_wdata,
   output logic [LINE_W-1:0] d_rdata,
   output logic              d_resp,
   output logic              l2_read,
   output logic              l2_write,
   output logic [ADDR_W-1:0] l2_addr,
   output logic [LINE_W-1:0] l2_wdata,
   input  logic [LINE_W-1:0] l2_rdata,
   input  logic              l2_resp
);

   arb_state_t        state_q, state_d;
   port_t             last_q, last_d;
   logic              load_d;
   logic              gnt_d_sel;
   logic              wr_q;
   logic [ADDR_W-1:0] addr_q;
   logic [LINE_W-1:0] wdata_q;
   logic              i_req, d_req;

   assign i_req = i_read;
   assign d_req = d_read | d_write;

   always_comb begin
      state_d   = state_q;
      last_d    = last_q;
      load_d    = 1'b0;
      gnt_d_sel = 1'b0;
      i_resp    = 1'b0;
      d_resp    = 1'b0;
      l2_read   = 1'b0;
      l2_write  = 1'b0;
      case (state_q)
         IDLE: begin
            // On a tie, grant the port that did not win last time.
            if (d_req && (!i_req || last_q == PORT_I)) begin
               state_d   = GNT_D;
               last_d    = PORT_D;
               load_d    = 1'b1;
               gnt_d_sel = 1'b1;
            end else if (i_req) begin
               state_d = GNT_I;
               last_d  = PORT_I;
               load_d  = 1'b1;
            end
         end
         GNT_I: begin
            l2_read = 1'b1;
            if (l2_resp) begin
               i_resp  = 1'b1;
               state_d = RELEASE;
            end
         end
         GNT_D: begin
            l2_write = wr_q;
            l2_read  = ~wr_q;
            if (l2_resp) begin
               d_resp  = 1'b1;
               state_d = RELEASE;
            end
         end
         RELEASE: state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         last_q  <= PORT_I;
         wr_q    <= 1'b0;
         addr_q  <= '0;
         wdata_q <= '0;
      end else begin
         state_q <= state_d;
         last_q  <= last_d;
         if (load_d) begin
            // Write wins when the D-cache raises both strobes.
            wr_q   <= gnt_d_sel & d_write;
            addr_q <= gnt_d_sel ? d_addr : i_addr;
            if (gnt_d_sel) wdata_q <= d_wdata;
         end
      end
   end

   assign l2_addr  = addr_q;
   assign l2_wdata = wdata_q;
   assign i_rdata  = l2_rdata;
   assign d_rdata  = l2_rdata;

endmodule

// File: tb/tb_l2_port_arbiter.sv
// Directed bench for l2_port_arbiter: inputs driven and outputs checked on the falling edge.
module tb_l2_port_arbiter;
   logic         clk = 1'b0;
   logic         rst;
   logic         i_read, d_read, d_write, l2_resp;
   logic [31:0]  i_addr, d_addr;
   logic [255:0] d_wdata, l2_rdata;
   logic [255:0] i_rdata, d_rdata, l2_wdata;
   logic [31:0]  l2_addr;
   logic         i_resp, d_resp, l2_read, l2_write;

   int total = 0;
   int bad   = 0;

   logic [255:0] line_aa, line_55, line_c3;

   l2_port_arbiter dut (
      .clk(clk), .rst(rst),
      .i_read(i_read), .i_addr(i_addr), .i_rdata(i_rdata), .i_resp(i_resp),
      .d_read(d_read), .d_write(d_write), .d_addr(d_addr), .d_wdata(d_wdata),
      .d_rdata(d_rdata), .d_resp(d_resp),
      .l2_read(l2_read), .l2_write(l2_write), .l2_addr(l2_addr), .l2_wdata(l2_wdata),
      .l2_rdata(l2_rdata), .l2_resp(l2_resp)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(negedge clk);
   endtask

   task automatic do_reset();
      rst = 1'b1; i_read = 0; d_read = 0; d_write = 0; l2_resp = 0;
      i_addr = '0; d_addr = '0; d_wdata = '0; l2_rdata = '0;
      tick(); tick();
      rst = 1'b0;
   endtask

   task automatic test_reset();
      do_reset();
      l2_rdata = line_c3;
      #1;
      total++; if ({l2_read, l2_write} !== 2'b00) begin bad++; $display("FAIL reset_strobes got=%b exp=00", {l2_read, l2_write}); end
      total++; if (l2_addr !== 32'h0) begin bad++; $display("FAIL reset_addr got=%h exp=0", l2_addr); end
      total++; if (l2_wdata !== 256'h0) begin bad++; $display("FAIL reset_wdata got=%h exp=0", l2_wdata); end
      total++; if ({i_resp, d_resp} !== 2'b00) begin bad++; $display("FAIL reset_resp got=%b exp=00", {i_resp, d_resp}); end
      total++; if (i_rdata !== line_c3 || d_rdata !== line_c3) begin bad++; $display("FAIL reset_rdata_pass i=%h d=%h exp=%h", i_rdata, d_rdata, line_c3); end
   endtask

   task automatic test_i_only();
      do_reset();
      tick();
      i_read = 1; i_addr = 32'h0000_0060;
      for (int c = 1; c <= 4; c++) begin
         tick();
         if (c == 4) begin l2_resp = 1; l2_rdata = line_aa; end
         #1;
         total++; if ({l2_read, l2_write} !== 2'b10) begin bad++; $display("FAIL i_only_strobe cyc=%0d got=%b exp=10", c, {l2_read, l2_write}); end
         total++; if (l2_addr !== 32'h60) begin bad++; $display("FAIL i_only_addr cyc=%0d got=%h exp=60", c, l2_addr); end
         total++; if (i_resp !== (c == 4) || d_resp !== 1'b0) begin bad++; $display("FAIL i_only_resp cyc=%0d got i=%b d=%b exp i=%b d=0", c, i_resp, d_resp, c == 4); end
      end
      total++; if (i_rdata !== line_aa) begin bad++; $display("FAIL i_only_rdata got=%h exp=%h", i_rdata, line_aa); end
      tick();
      l2_resp = 0; i_read = 0;
      #1;
      total++; if ({l2_read, l2_write, i_resp, d_resp} !== 4'b0) begin bad++; $display("FAIL i_only_release got=%b exp=0000", {l2_read, l2_write, i_resp, d_resp}); end
      tick(); tick(); #1;
      total++; if ({l2_read, l2_write} !== 2'b00) begin bad++; $display("FAIL i_only_idle got=%b exp=00", {l2_read, l2_write}); end
   endtask

   task automatic test_d_write();
      do_reset();
      tick();
      d_write = 1; d_addr = 32'h0000_1000; d_wdata = line_55;
      tick(); #1;
      total++; if ({l2_read, l2_write} !== 2'b01) begin bad++; $display("FAIL dwr_strobe got=%b exp=01", {l2_read, l2_write}); end
      total++; if (l2_addr !== 32'h1000) begin bad++; $display("FAIL dwr_addr got=%h exp=1000", l2_addr); end
      total++; if (l2_wdata !== line_55) begin bad++; $display("FAIL dwr_wdata got=%h exp=%h", l2_wdata, line_55); end
      // registered: changing the requester's data must not disturb the grant
      d_wdata = line_c3;
      tick(); #1;
      total++; if (l2_wdata !== line_55 || l2_write !== 1'b1) begin bad++; $display("FAIL dwr_stable wdata=%h wr=%b exp=%h 1", l2_wdata, l2_write, line_55); end
      l2_resp = 1; #1;
      total++; if ({i_resp, d_resp} !== 2'b01) begin bad++; $display("FAIL dwr_resp got=%b exp=01", {i_resp, d_resp}); end
      tick(); l2_resp = 0; d_write = 0; tick();
   endtask

   task automatic test_tie();
      do_reset();
      tick();
      i_read = 1; i_addr = 32'h0000_0200; d_read = 1; d_addr = 32'h0000_3400;
      tick(); #1;
      total++; if (l2_addr !== 32'h3400 || l2_read !== 1'b1) begin bad++; $display("FAIL tie_first addr=%h rd=%b exp=3400 1", l2_addr, l2_read); end
      l2_resp = 1; #1;
      total++; if ({i_resp, d_resp} !== 2'b01) begin bad++; $display("FAIL tie_first_resp got=%b exp=01", {i_resp, d_resp}); end
      tick(); l2_resp = 0; d_read = 0; #1;
      total++; if ({l2_read, l2_write, i_resp} !== 3'b0) begin bad++; $display("FAIL tie_release got=%b exp=000", {l2_read, l2_write, i_resp}); end
      tick(); #1;
      total++; if (l2_read !== 1'b0) begin bad++; $display("FAIL tie_idle_gap got=%b exp=0", l2_read); end
      tick(); #1;
      total++; if (l2_addr !== 32'h0200 || l2_read !== 1'b1) begin bad++; $display("FAIL tie_second addr=%h rd=%b exp=200 1", l2_addr, l2_read); end
      l2_resp = 1; #1;
      total++; if ({i_resp, d_resp} !== 2'b10) begin bad++; $display("FAIL tie_second_resp got=%b exp=10", {i_resp, d_resp}); end
      tick(); l2_resp = 0; i_read = 0; tick();
   endtask

   task automatic test_back_to_back();
      logic exp_d;
      do_reset();
      tick();
      i_read = 1; i_addr = 32'h0000_0A00; d_read = 1; d_addr = 32'h0000_0D00;
      for (int t = 0; t < 6; t++) begin
         exp_d = (t % 2 == 0);
         tick();
         l2_resp = 1; #1;
         total++; if (l2_addr !== (exp_d ? 32'h0D00 : 32'h0A00)) begin bad++; $display("FAIL b2b_addr txn=%0d got=%h exp_d=%b", t, l2_addr, exp_d); end
         total++; if ({i_resp, d_resp} !== {~exp_d, exp_d}) begin bad++; $display("FAIL b2b_order txn=%0d got=%b exp=%b", t, {i_resp, d_resp}, {~exp_d, exp_d}); end
         tick(); l2_resp = 0;
         tick();
      end
      i_read = 0; d_read = 0;
      tick(); tick();
   endtask

   task automatic test_reset_mid();
      do_reset();
      tick();
      d_write = 1; d_addr = 32'h0000_7700; d_wdata = line_55;
      tick(); #1;
      total++; if (l2_write !== 1'b1) begin bad++; $display("FAIL rmid_pre got=%b exp=1", l2_write); end
      rst = 1;
      tick();
      rst = 0; d_write = 0; #1;
      total++; if ({l2_read, l2_write, i_resp, d_resp} !== 4'b0 || l2_addr !== 32'h0) begin bad++; $display("FAIL rmid_after st=%b addr=%h exp=0000 0", {l2_read, l2_write, i_resp, d_resp}, l2_addr); end
      l2_resp = 1; #1;
      total++; if ({i_resp, d_resp} !== 2'b00) begin bad++; $display("FAIL rmid_stray got=%b exp=00", {i_resp, d_resp}); end
      tick(); l2_resp = 0;
      i_read = 1; i_addr = 32'h0000_0440;
      tick(); #1;
      total++; if (l2_read !== 1'b1 || l2_write !== 1'b0 || l2_addr !== 32'h0440) begin bad++; $display("FAIL rmid_fresh rd=%b wr=%b addr=%h exp=1 0 440", l2_read, l2_write, l2_addr); end
      l2_resp = 1; #1;
      total++; if ({i_resp, d_resp} !== 2'b10) begin bad++; $display("FAIL rmid_fresh_resp got=%b exp=10", {i_resp, d_resp}); end
      tick(); l2_resp = 0; i_read = 0; tick();
   endtask

   task automatic test_stray_resp();
      do_reset();
      tick();
      l2_resp = 1; #1;
      total++; if ({i_resp, d_resp} !== 2'b00) begin bad++; $display("FAIL stray_idle got=%b exp=00", {i_resp, d_resp}); end
      tick(); l2_resp = 0; #1;
      total++; if ({l2_read, l2_write} !== 2'b00) begin bad++; $display("FAIL stray_idle_state got=%b exp=00", {l2_read, l2_write}); end
      d_read = 1; d_addr = 32'h0000_0880;
      tick(); l2_resp = 1; #1;
      total++; if (d_resp !== 1'b1) begin bad++; $display("FAIL stray_setup got=%b exp=1", d_resp); end
      // resp held high into RELEASE must be ignored
      tick(); d_read = 0; #1;
      total++; if ({i_resp, d_resp, l2_read} !== 3'b000) begin bad++; $display("FAIL stray_release got=%b exp=000", {i_resp, d_resp, l2_read}); end
      tick(); l2_resp = 0; #1;
      total++; if ({l2_read, l2_write} !== 2'b00) begin bad++; $display("FAIL stray_release_next got=%b exp=00", {l2_read, l2_write}); end
      tick(); #1;
      total++; if ({l2_read, l2_write} !== 2'b00) begin bad++; $display("FAIL stray_final got=%b exp=00", {l2_read, l2_write}); end
   endtask

   initial begin
      line_aa = {8{32'hAAAA_AAAA}};
      line_55 = {8{32'h5555_5555}};
      line_c3 = {8{32'hC3C3_3C3C}};
      test_reset();
      test_i_only();
      test_d_write();
      test_tie();
      test_back_to_back();
      test_reset_mid();
      test_stray_resp();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
